// File: rtl/axi4_slave_strb_memory_if.sv
// Request/response bus of the byte-strobed memory slave.
// The requester uses the master modport, the memory uses the slave modport.
interface axi4_slave_strb_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_write;
    logic                    rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
    );
endinterface

// File: rtl/axi4_slave_strb_memory.sv
// Word-organised memory with byte-lane write strobes, a fixed-latency response
// pipeline and a response FIFO sized so credits alone prevent overflow.
module axi4_slave_strb_memory #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_BYTES = 65536,
    parameter int RD_LATENCY  = 2
) (
    input logic                     sys_clk,
    input logic                     rst,
    axi4_slave_strb_memory_if.slave bus
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int WORDS      = DEPTH_BYTES / BYTES;
    localparam int LANE_BITS  = $clog2(BYTES);
    localparam int IDX_BITS   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int FIFO_DEPTH = RD_LATENCY + 1;
    localparam int CNT_W      = $clog2(RD_LATENCY + 2);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                  write;
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic                  accept;
    logic                  pop;
    logic                  push;
    logic                  in_range;
    logic [IDX_BITS-1:0]   word_idx;
    rsp_t                  entry_in;
    rsp_t                  push_data;
    rsp_t                  fifo [FIFO_DEPTH];
    rsp_t                  head;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      outstanding_next;
    logic                  req_ready_q;
    logic                  rsp_valid;

    assign accept   = bus.req_valid && req_ready_q && !rst;
    assign in_range = {1'b0, bus.req_addr} < (ADDR_WIDTH + 1)'(DEPTH_BYTES);
    assign word_idx = bus.req_addr[LANE_BITS +: IDX_BITS];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch can be inferred.
        entry_in       = '0;
        entry_in.write = bus.req_write;
        entry_in.err   = !in_range;
        if (in_range && !bus.req_write) entry_in.rdata = mem[word_idx];
    end

    // NOTE: storage arrays are deliberately left out of reset; contents must survive it.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (accept && bus.req_write && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.req_wstrb[b]) mem[word_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
        end
    end

    // The FIFO write is the final latency stage, so only RD_LATENCY-1 registers precede it.
    generate
        if (RD_LATENCY == 1) begin : g_direct
            assign push      = accept;
            assign push_data = entry_in;
        end else begin : g_pipe
            logic pipe_v [RD_LATENCY-1];
            rsp_t pipe_d [RD_LATENCY-1];

            always_ff @(posedge sys_clk) begin
                if (rst) begin
                    for (int i = 0; i < RD_LATENCY - 1; i++) pipe_v[i] <= 1'b0;
                end else begin
                    pipe_v[0] <= accept;
                    pipe_d[0] <= entry_in;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        pipe_v[i] <= pipe_v[i-1];
                        pipe_d[i] <= pipe_d[i-1];
                    end
                end
            end

            assign push      = pipe_v[RD_LATENCY-2];
            assign push_data = pipe_d[RD_LATENCY-2];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge sys_clk) begin
        if (push && !rst) fifo[wr_ptr] <= push_data;
    end

    always_comb begin
        outstanding_next = outstanding;
        if (accept && !pop)      outstanding_next = outstanding + CNT_W'(1);
        else if (!accept && pop) outstanding_next = outstanding - CNT_W'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            req_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt    <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            outstanding <= outstanding_next;
            req_ready_q <= outstanding_next < CNT_W'(RD_LATENCY + 1);
        end
    end

    // Outputs read zero while empty, so unreset FIFO storage never leaks out.
    assign head          = fifo[rd_ptr];
    assign rsp_valid     = fifo_cnt != '0;
    assign pop           = rsp_valid && bus.rsp_ready;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_valid ? head.rdata : '0;
    assign bus.rsp_write = rsp_valid ? head.write : 1'b0;
    assign bus.rsp_err   = rsp_valid ? head.err : 1'b0;
endmodule
